matmul_seq: RTL and testbench

MATMUL_SEQ -- requirements
Module: matmul_seq

---
 rtl/matmul_seq_pkg.sv | 20 ++
 rtl/matmul_seq_mac.sv | 34 +++
 rtl/matmul_seq.sv | 111 +++++++++++
 tb/tb_matmul_seq.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/matmul_seq_pkg.sv
// Shared types and width derivations for the sequential matrix multiplier.
package matmul_seq_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    // Result element width: a dot product of DIM unsigned W x W products.
    function automatic int calc_yw(input int dim, input int w);
        return 2 * w + $clog2(dim);
    endfunction

    // Row index must also represent DIM, which marks the flush cycle.
    function automatic int calc_idx_w(input int dim);
        return $clog2(dim + 1);
    endfunction

endpackage

// File: rtl/matmul_seq_mac.sv
// One multiply-accumulate lane: unsigned W x W product added into a YW-bit accumulator.
module mac_lane
    import matmul_seq_pkg::*;
#(
    parameter int DIM = 2,
    parameter int W   = 8,
    localparam int YW = calc_yw(DIM, W)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          en,
    input  logic [W-1:0]  a,
    input  logic [W-1:0]  b,
    output logic [YW-1:0] sum
);

    logic [2*W-1:0] prod;
    logic [YW-1:0]  acc;

    assign prod = a * b;
    assign sum  = acc + {{(YW - 2 * W){1'b0}}, prod};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
        end else if (clr) begin
            acc <= '0;
        end else if (en) begin
            acc <= sum;
        end
    end

endmodule

// File: rtl/matmul_seq.sv
// Sequential DIM x DIM unsigned matrix multiplier: one row-index/inner-index step per cycle,
// DIM parallel MAC lanes produce a full result row every DIM cycles.
module matmul_seq
    import matmul_seq_pkg::*;
#(
    parameter int DIM = 2,
    parameter int W   = 8,
    localparam int YW = calc_yw(DIM, W)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DIM*DIM*W-1:0]  a,
    input  logic [DIM*DIM*W-1:0]  b,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DIM*DIM*YW-1:0] y
);

    localparam int IW = calc_idx_w(DIM);
    localparam logic [IW-1:0] K_LAST = IW'(DIM - 1);
    localparam logic [IW-1:0] I_END  = IW'(DIM);

    state_t               state, state_nxt;
    logic [DIM*DIM*W-1:0] a_q, b_q;
    logic [IW-1:0]        i_q, k_q;
    logic                 capture, mac_en, row_end;
    logic [W-1:0]         a_sel;
    logic [W-1:0]         b_sel [DIM];
    logic [YW-1:0]        sum   [DIM];

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign capture   = in_ready && in_valid;
    // i_q == DIM is a one-cycle flush after the last row before DONE.
    assign mac_en    = (state == CALC) && (i_q != I_END);
    assign row_end   = mac_en && (k_q == K_LAST);

    always_comb begin
        a_sel = '0;
        for (int j = 0; j < DIM; j++) begin
            b_sel[j] = '0;
        end
        if (mac_en) begin
            a_sel = a_q[(int'(i_q) * DIM + int'(k_q)) * W +: W];
            for (int j = 0; j < DIM; j++) begin
                b_sel[j] = b_q[(int'(k_q) * DIM + j) * W +: W];
            end
        end
    end

    for (genvar j = 0; j < DIM; j++) begin : g_lane
        mac_lane #(
            .DIM(DIM),
            .W  (W)
        ) u_lane (
            .clk  (clk),
            .rst_n(rst_n),
            .clr  (capture || row_end),
            .en   (mac_en),
            .a    (a_sel),
            .b    (b_sel[j]),
            .sum  (sum[j])
        );
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid) state_nxt = CALC;
            CALC:    if (i_q == I_END) state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q <= '0;
            b_q <= '0;
            i_q <= '0;
            k_q <= '0;
            y   <= '0;
        end else if (capture) begin
            a_q <= a;
            b_q <= b;
            i_q <= '0;
            k_q <= '0;
        end else if (mac_en) begin
            if (row_end) begin
                k_q <= '0;
                i_q <= i_q + IW'(1);
                for (int j = 0; j < DIM; j++) begin
                    y[(int'(i_q) * DIM + j) * YW +: YW] <= sum[j];
                end
            end else begin
                k_q <= k_q + IW'(1);
            end
        end
    end

endmodule

// File: tb/tb_matmul_seq.sv
// Bench for matmul_seq at DIM=2 and DIM=3 (W=8): vector table, scoreboard, handshake corner cases.
module tb_matmul_seq;

    typedef logic [3:0][7:0]  vec2_t;
    typedef logic [3:0][16:0] y2_t;
    typedef logic [8:0][7:0]  vec3_t;
    typedef logic [8:0][17:0] y3_t;

    typedef struct packed {
        vec2_t a;
        vec2_t b;
        y2_t   y;
    } rec2_t;

    logic  clk = 1'b0;
    logic  rst_n;
    logic  in_valid2, in_ready2, out_valid2, out_ready2;
    vec2_t a2, b2;
    y2_t   y2;
    logic  in_valid3, in_ready3, out_valid3, out_ready3;
    vec3_t a3, b3;
    y3_t   y3;

    int  n_checks = 0;
    int  n_pass   = 0;
    y2_t q2[$];
    y3_t q3[$];

    always #5 clk = ~clk;

    matmul_seq #(.DIM(2), .W(8)) dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid2), .in_ready(in_ready2),
        .a(a2), .b(b2), .out_valid(out_valid2), .out_ready(out_ready2), .y(y2)
    );

    matmul_seq #(.DIM(3), .W(8)) dut3 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid3), .in_ready(in_ready3),
        .a(a3), .b(b3), .out_valid(out_valid3), .out_ready(out_ready3), .y(y3)
    );

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic vec2_t mk2(input int e0, input int e1, input int e2, input int e3);
        vec2_t r;
        r[0] = 8'(e0); r[1] = 8'(e1); r[2] = 8'(e2); r[3] = 8'(e3);
        return r;
    endfunction

    function automatic y2_t mky2(input int e0, input int e1, input int e2, input int e3);
        y2_t r;
        r[0] = 17'(e0); r[1] = 17'(e1); r[2] = 17'(e2); r[3] = 17'(e3);
        return r;
    endfunction

    function automatic vec2_t rnd2();
        vec2_t r;
        for (int e = 0; e < 4; e++) r[e] = 8'($urandom_range(0, 255));
        return r;
    endfunction

    function automatic vec3_t rnd3();
        vec3_t r;
        for (int e = 0; e < 9; e++) r[e] = 8'($urandom_range(0, 255));
        return r;
    endfunction

    function automatic y2_t model2(input vec2_t am, input vec2_t bm);
        y2_t r;
        for (int i = 0; i < 2; i++)
            for (int j = 0; j < 2; j++) begin
                int s = 0;
                for (int k = 0; k < 2; k++) s += int'(am[i*2+k]) * int'(bm[k*2+j]);
                r[i*2+j] = 17'(s);
            end
        return r;
    endfunction

    function automatic y3_t model3(input vec3_t am, input vec3_t bm);
        y3_t r;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++) begin
                int s = 0;
                for (int k = 0; k < 3; k++) s += int'(am[i*3+k]) * int'(bm[k*3+j]);
                r[i*3+j] = 18'(s);
            end
        return r;
    endfunction

    // Scoreboards: a handshake happens at the next rising edge when both are high at the falling edge.
    always @(negedge clk) begin
        if (rst_n && out_valid2 && out_ready2) begin
            if (q2.size() == 0) chk("y2_unexpected_output", q2.size(), 1);
            else chk("y2_result", y2, q2.pop_front());
        end
        if (rst_n && out_valid3 && out_ready3) begin
            if (q3.size() == 0) chk("y3_unexpected_output", q3.size(), 1);
            else chk("y3_result", y3, q3.pop_front());
        end
    end

    task automatic run2(input vec2_t av, input vec2_t bv, input y2_t ev, input string tag);
        int n = 0;
        while (!in_ready2 && n < 100) begin @(posedge clk); #1; n++; end
        chk({tag, "_in_ready"}, in_ready2, 1);
        a2 = av; b2 = bv; in_valid2 = 1'b1;
        q2.push_back(ev);
        @(posedge clk); #1;
        in_valid2 = 1'b0; a2 = rnd2(); b2 = rnd2();
        n = 0;
        while (!out_valid2 && n < 50) begin @(posedge clk); #1; n++; end
        chk({tag, "_latency"}, n, 5);
        @(posedge clk); #1;
    endtask

    task automatic run3(input vec3_t av, input vec3_t bv, input y3_t ev, input string tag);
        int n = 0;
        while (!in_ready3 && n < 100) begin @(posedge clk); #1; n++; end
        chk({tag, "_in_ready"}, in_ready3, 1);
        a3 = av; b3 = bv; in_valid3 = 1'b1;
        q3.push_back(ev);
        @(posedge clk); #1;
        in_valid3 = 1'b0; a3 = rnd3(); b3 = rnd3();
        n = 0;
        while (!out_valid3 && n < 80) begin @(posedge clk); #1; n++; end
        chk({tag, "_latency"}, n, 10);
        @(posedge clk); #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: time %0t reached limit 500000", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        rec2_t tbl[7];
        vec2_t ta, tb;
        y2_t   te;
        vec3_t ia, ib, oa;
        y3_t   ie, oe;
        int    n, first_rise, second_rise;
        logic  prev;

        tbl[0] = '{a: mk2(1, 2, 3, 4),       b: mk2(5, 6, 7, 8),         y: mky2(19, 22, 43, 50)};
        tbl[1] = '{a: mk2(255, 255, 255, 255), b: mk2(255, 255, 255, 255), y: mky2(130050, 130050, 130050, 130050)};
        tbl[2] = '{a: mk2(0, 0, 0, 0),       b: mk2(9, 8, 7, 6),         y: mky2(0, 0, 0, 0)};
        tbl[3] = '{a: mk2(1, 0, 0, 1),       b: mk2(10, 20, 30, 40),     y: mky2(10, 20, 30, 40)};
        tbl[4] = '{a: mk2(2, 0, 0, 3),       b: mk2(1, 1, 1, 1),         y: mky2(2, 2, 3, 3)};
        tbl[5] = '{a: mk2(1, 1, 1, 1),       b: mk2(200, 100, 50, 25),   y: mky2(250, 125, 250, 125)};
        tbl[6] = '{a: mk2(255, 0, 0, 255),   b: mk2(255, 1, 2, 255),     y: mky2(65025, 255, 510, 65025)};

        rst_n = 1'b0;
        in_valid2 = 1'b0; out_ready2 = 1'b1; a2 = '0; b2 = '0;
        in_valid3 = 1'b0; out_ready3 = 1'b1; a3 = '0; b3 = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready2", in_ready2, 1);
        chk("rst_out_valid2", out_valid2, 0);
        chk("rst_y2", y2, 0);
        chk("rst_in_ready3", in_ready3, 1);
        chk("rst_out_valid3", out_valid3, 0);
        chk("rst_y3", y3, 0);
        rst_n = 1'b1;

        for (int i = 0; i < 7; i++) run2(tbl[i].a, tbl[i].b, tbl[i].y, $sformatf("vec%0d", i));
        for (int i = 0; i < 4; i++) begin
            ta = rnd2(); tb = rnd2();
            run2(ta, tb, model2(ta, tb), $sformatf("rnd2_%0d", i));
        end

        // DIM=3: identity x B, ones x ones, random
        for (int e = 0; e < 9; e++) begin
            ia[e] = (e % 4 == 0) ? 8'd1 : 8'd0;
            ib[e] = 8'(e + 1);
            ie[e] = 18'(e + 1);
            oa[e] = 8'd1;
            oe[e] = 18'd3;
        end
        run3(ia, ib, ie, "d3_identity");
        run3(oa, oa, oe, "d3_ones");
        ia = rnd3(); ib = rnd3();
        run3(ia, ib, model3(ia, ib), "d3_rnd");

        // Backpressure: hold DONE for 6 cycles while poking in_valid
        te = mky2(17, 33, 22, 42);
        out_ready2 = 1'b0;
        a2 = mk2(3, 1, 4, 1); b2 = mk2(5, 9, 2, 6); in_valid2 = 1'b1;
        q2.push_back(te);
        @(posedge clk); #1;
        in_valid2 = 1'b0;
        n = 0;
        while (!out_valid2 && n < 50) begin @(posedge clk); #1; n++; end
        chk("bp_latency", n, 5);
        for (int c = 0; c < 6; c++) begin
            in_valid2 = 1'b1; a2 = rnd2(); b2 = rnd2();
            @(posedge clk); #1;
            chk("bp_out_valid_held", out_valid2, 1);
            chk("bp_y_stable", y2, te);
            chk("bp_in_ready_low", in_ready2, 0);
        end
        in_valid2 = 1'b0;
        out_ready2 = 1'b1;
        @(posedge clk); #1;
        chk("bp_out_valid_dropped", out_valid2, 0);
        chk("bp_in_ready_back", in_ready2, 1);
        chk("bp_y_retained", y2, te);
        n = 0;
        repeat (8) begin @(posedge clk); #1; if (out_valid2) n++; end
        chk("bp_ignored_not_queued", n, 0);

        // Reset after two CALC cycles discards the product
        a2 = mk2(9, 9, 9, 9); b2 = mk2(9, 9, 9, 9); in_valid2 = 1'b1;
        @(posedge clk); #1;
        in_valid2 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", out_valid2, 0);
        chk("mid_rst_in_ready", in_ready2, 1);
        chk("mid_rst_y", y2, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        n = 0;
        repeat (10) begin @(posedge clk); #1; if (out_valid2) n++; end
        chk("mid_rst_no_pulse", n, 0);
        run2(mk2(7, 0, 1, 2), mk2(1, 2, 3, 4), mky2(7, 14, 7, 10), "after_rst");

        // Back-to-back: in_valid held across two operand sets
        a2 = tbl[0].a; b2 = tbl[0].b; in_valid2 = 1'b1;
        q2.push_back(tbl[0].y);
        @(posedge clk); #1;
        a2 = tbl[1].a; b2 = tbl[1].b;
        q2.push_back(tbl[1].y);
        first_rise = -1; second_rise = -1; prev = 1'b0;
        for (int e = 1; e <= 20; e++) begin
            @(posedge clk); #1;
            if (out_valid2 && !prev) begin
                if (first_rise < 0) first_rise = e;
                else if (second_rise < 0) second_rise = e;
            end
            prev = out_valid2;
            if (e == 6) chk("b2b_idle_after_handshake", in_ready2, 1);
            if (e == 7) begin
                chk("b2b_second_captured", in_ready2, 0);
                in_valid2 = 1'b0;
            end
        end
        chk("b2b_first_rise", first_rise, 5);
        chk("b2b_second_rise", second_rise, 12);

        repeat (3) @(posedge clk);
        #1;
        chk("q2_drained", q2.size(), 0);
        chk("q3_drained", q3.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
